mem_bus_arbiter: RTL and testbench

//  Two-master, one-slave arbiter for the cache-line memory bus (mem_bus_req_t / mem_bus_resp_t).

---
 rtl/mem_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the cache-line memory bus: I-cache and D-cache
// share one backing memory, with a registered forwarded request and a stall watchdog.

package mem_bus_pkg;
  localparam int ADDR_W = 58;
  localparam int DATA_W = 512;

  typedef struct packed {
    logic              mem_req_load;
    logic              mem_req_store;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_data;
  } mem_bus_req_t;

  typedef struct packed {
    logic              mem_ready;
    logic [DATA_W-1:0] mem_data;
  } mem_bus_resp_t;
endpackage

module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 1024,
  parameter bit          DC_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  mem_bus_req_t  ic_req,
  output mem_bus_resp_t ic_resp,
  input  mem_bus_req_t  dc_req,
  output mem_bus_resp_t dc_resp,
  output mem_bus_req_t  mem_req,
  input  mem_bus_resp_t mem_resp,
  output logic          busy,
  output logic          bus_timeout,
  output logic          proto_err
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, GRANT, RESP, DROP} state_t;
  typedef enum logic {MST_IC = 1'b0, MST_DC = 1'b1} master_t;

  state_t           state;
  master_t          owner;
  logic             ptr_dc;
  logic [CNT_W-1:0] count;

  logic         ic_pend;
  logic         dc_pend;
  logic         pick_dc;
  logic         owner_live;
  logic         timeout_hit;
  mem_bus_req_t grant_req;

  assign ic_pend = ic_req.mem_req_load | ic_req.mem_req_store;
  assign dc_pend = dc_req.mem_req_load | dc_req.mem_req_store;

  // DC wins when it alone is pending, or on a conflict when the pointer favours it.
  assign pick_dc   = dc_pend & (~ic_pend | ptr_dc);
  assign grant_req = pick_dc ? dc_req : ic_req;

  assign owner_live = (owner == MST_DC) ? dc_pend : ic_pend;
  assign timeout_hit = (TIMEOUT != 0) && (count == CNT_LAST);

  assign busy = (state != IDLE);

  // NOTE: all state below is sequential, so every assignment is non-blocking (<=);
  // blocking assignments here would create order-dependent races between registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= MST_IC;
      ptr_dc      <= DC_FIRST;
      count       <= '0;
      // NOTE: the wide request/response registers are reset too because they drive
      // outputs that must read all-zero straight out of reset.
      mem_req     <= '0;
      ic_resp     <= '0;
      dc_resp     <= '0;
      bus_timeout <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ic_pend | dc_pend) begin
            owner   <= pick_dc ? MST_DC : MST_IC;
            ptr_dc  <= ~pick_dc;
            count   <= '0;
            mem_req <= grant_req;
            // Load+store together is illegal; the store wins so no write is lost.
            if (grant_req.mem_req_load && grant_req.mem_req_store) begin
              mem_req.mem_req_load <= 1'b0;
              proto_err            <= 1'b1;
            end
            if (pick_dc) ic_resp <= '0;
            else         dc_resp <= '0;
            state <= GRANT;
          end
        end

        GRANT: begin
          if (mem_resp.mem_ready) begin
            mem_req <= '0;
            if (owner == MST_DC) begin
              dc_resp.mem_ready <= 1'b1;
              dc_resp.mem_data  <= mem_resp.mem_data;
            end else begin
              ic_resp.mem_ready <= 1'b1;
              ic_resp.mem_data  <= mem_resp.mem_data;
            end
            state <= RESP;
          end else if (timeout_hit) begin
            // Abort: the master still gets its one ready pulse, with zeroed data.
            mem_req     <= '0;
            bus_timeout <= 1'b1;
            if (owner == MST_DC) begin
              dc_resp.mem_ready <= 1'b1;
              dc_resp.mem_data  <= '0;
            end else begin
              ic_resp.mem_ready <= 1'b1;
              ic_resp.mem_data  <= '0;
            end
            state <= RESP;
          end else if (TIMEOUT != 0) begin
            count <= count + 1'b1;
          end
        end

        RESP: begin
          ic_resp.mem_ready <= 1'b0;
          dc_resp.mem_ready <= 1'b0;
          state             <= DROP;
        end

        DROP: begin
          if (!owner_live) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a cycle table for basic and round-robin
// traffic, then hand sequences for protocol error, watchdog, reset and release.

module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  mem_bus_req_t  ic_req, dc_req;
  mem_bus_resp_t mem_resp;

  mem_bus_resp_t ic_resp, dc_resp;
  mem_bus_req_t  mem_req;
  logic          busy, bus_timeout, proto_err;

  mem_bus_resp_t ic_resp_b, dc_resp_b;
  mem_bus_req_t  mem_req_b;
  logic          busy_b, bus_timeout_b, proto_err_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT(8), .DC_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_resp(ic_resp),
    .dc_req(dc_req), .dc_resp(dc_resp),
    .mem_req(mem_req), .mem_resp(mem_resp),
    .busy(busy), .bus_timeout(bus_timeout), .proto_err(proto_err)
  );

  mem_bus_arbiter #(.TIMEOUT(8), .DC_FIRST(1'b0)) u_dut_ic_first (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_resp(ic_resp_b),
    .dc_req(dc_req), .dc_resp(dc_resp_b),
    .mem_req(mem_req_b), .mem_resp(mem_resp),
    .busy(busy_b), .bus_timeout(bus_timeout_b), .proto_err(proto_err_b)
  );

  typedef struct {
    logic       rst;
    logic       ic_ld, ic_st;
    logic [7:0] ic_a;
    logic       dc_ld, dc_st;
    logic [7:0] dc_a;
    logic       mrdy;
    logic [7:0] mdat;
    logic       e_busy, e_ld, e_st;
    logic [7:0] e_a;
    logic       e_icr, e_dcr;
    logic [7:0] e_dat;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic il, input logic is, input logic [7:0] ia,
                              input logic dl, input logic ds, input logic [7:0] da,
                              input logic mr, input logic [7:0] md,
                              input logic eb, input logic el, input logic es, input logic [7:0] ea,
                              input logic eir, input logic edr, input logic [7:0] ed);
    vec_t v;
    v.rst = r; v.ic_ld = il; v.ic_st = is; v.ic_a = ia;
    v.dc_ld = dl; v.dc_st = ds; v.dc_a = da; v.mrdy = mr; v.mdat = md;
    v.e_busy = eb; v.e_ld = el; v.e_st = es; v.e_a = ea;
    v.e_icr = eir; v.e_dcr = edr; v.e_dat = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic il, input logic is, input logic [7:0] ia,
                       input logic dl, input logic ds, input logic [7:0] da,
                       input logic mr, input logic [7:0] md);
    ic_req = '0;
    ic_req.mem_req_load  = il;
    ic_req.mem_req_store = is;
    ic_req.mem_req_addr  = ADDR_W'(ia);
    dc_req = '0;
    dc_req.mem_req_load  = dl;
    dc_req.mem_req_store = ds;
    dc_req.mem_req_addr  = ADDR_W'(da);
    mem_resp.mem_ready = mr;
    mem_resp.mem_data  = {64{md}};
  endtask

  initial begin
    vec_t v;
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00);

    // Uncontended IC load, memory ready 3 cycles after mem_req is valid.
    vq.push_back(mk(1, 0,0,8'h00, 0,0,8'h00, 0,8'h00, 0,0,0,8'h00, 0,0,8'h00));
    vq.push_back(mk(0, 1,0,8'h10, 0,0,8'h00, 0,8'h00, 1,1,0,8'h10, 0,0,8'h00));
    vq.push_back(mk(0, 1,0,8'h10, 0,0,8'h00, 0,8'h00, 1,1,0,8'h10, 0,0,8'h00));
    vq.push_back(mk(0, 1,0,8'h10, 0,0,8'h00, 0,8'h00, 1,1,0,8'h10, 0,0,8'h00));
    vq.push_back(mk(0, 1,0,8'h10, 0,0,8'h00, 1,8'hC3, 1,0,0,8'h00, 1,0,8'hC3));
    vq.push_back(mk(0, 1,0,8'h10, 0,0,8'h00, 0,8'h00, 1,0,0,8'h00, 0,0,8'h00));
    vq.push_back(mk(0, 0,0,8'h10, 0,0,8'h00, 0,8'h00, 0,0,0,8'h00, 0,0,8'h00));
    // Conflict: DC first, IC after one idle cycle, then the same pair again.
    vq.push_back(mk(1, 0,0,8'h00, 0,0,8'h00, 0,8'h00, 0,0,0,8'h00, 0,0,8'h00));
    for (int k = 0; k < 2; k++) begin
      logic [7:0] d0, d1;
      d0 = (k == 0) ? 8'h3C : 8'h11;
      d1 = (k == 0) ? 8'h5A : 8'h22;
      vq.push_back(mk(0, 1,0,8'h20, 1,0,8'h40, 0,8'h00, 1,1,0,8'h40, 0,0,8'h00));
      vq.push_back(mk(0, 1,0,8'h20, 1,0,8'h40, 1,d0,    1,0,0,8'h00, 0,1,d0));
      vq.push_back(mk(0, 1,0,8'h20, 1,0,8'h40, 0,8'h00, 1,0,0,8'h00, 0,0,8'h00));
      vq.push_back(mk(0, 1,0,8'h20, 0,0,8'h40, 0,8'h00, 0,0,0,8'h00, 0,0,8'h00));
      vq.push_back(mk(0, 1,0,8'h20, 0,0,8'h40, 0,8'h00, 1,1,0,8'h20, 0,0,8'h00));
      vq.push_back(mk(0, 1,0,8'h20, 0,0,8'h40, 1,d1,    1,0,0,8'h00, 1,0,d1));
      vq.push_back(mk(0, 1,0,8'h20, 0,0,8'h40, 0,8'h00, 1,0,0,8'h00, 0,0,8'h00));
      vq.push_back(mk(0, 0,0,8'h20, 0,0,8'h40, 0,8'h00, 0,0,0,8'h00, 0,0,8'h00));
    end

    foreach (vq[i]) begin
      v = vq[i];
      rst = v.rst;
      drive(v.ic_ld, v.ic_st, v.ic_a, v.dc_ld, v.dc_st, v.dc_a, v.mrdy, v.mdat);
      step();
      check($sformatf("v%0d busy", i), 576'(busy), 576'(v.e_busy));
      check($sformatf("v%0d req_load", i), 576'(mem_req.mem_req_load), 576'(v.e_ld));
      check($sformatf("v%0d req_store", i), 576'(mem_req.mem_req_store), 576'(v.e_st));
      check($sformatf("v%0d req_addr", i), 576'(mem_req.mem_req_addr), 576'(v.e_a));
      check($sformatf("v%0d ic_ready", i), 576'(ic_resp.mem_ready), 576'(v.e_icr));
      check($sformatf("v%0d dc_ready", i), 576'(dc_resp.mem_ready), 576'(v.e_dcr));
      if (v.e_icr) check($sformatf("v%0d ic_data", i), 576'(ic_resp.mem_data), 576'({64{v.e_dat}}));
      if (v.e_dcr) check($sformatf("v%0d dc_data", i), 576'(dc_resp.mem_data), 576'({64{v.e_dat}}));
    end
    rst = 1'b0;

    // Load and store together from DC: store forwarded, proto_err sticky.
    check("pe before", 576'(proto_err), 576'(0));
    drive(0, 0, 8'h00, 1, 1, 8'h80, 0, 8'h00);
    dc_req.mem_req_data = {64{8'hA5}};
    step();
    check("pe store", 576'(mem_req.mem_req_store), 576'(1));
    check("pe load", 576'(mem_req.mem_req_load), 576'(0));
    check("pe addr", 576'(mem_req.mem_req_addr), 576'(8'h80));
    check("pe data", 576'(mem_req.mem_req_data), 576'({64{8'hA5}}));
    check("pe flag", 576'(proto_err), 576'(1));
    mem_resp.mem_ready = 1'b1;
    mem_resp.mem_data  = {64{8'h77}};
    step();
    check("pe dc_ready", 576'(dc_resp.mem_ready), 576'(1));
    check("pe dc_data", 576'(dc_resp.mem_data), 576'({64{8'h77}}));
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00);
    step();
    step();
    check("pe idle", 576'(busy), 576'(0));
    check("pe sticky", 576'(proto_err), 576'(1));
    check("pe no timeout", 576'(bus_timeout), 576'(0));

    // Watchdog: memory never ready, abort after 8 GRANT cycles.
    drive(1, 0, 8'h30, 0, 0, 8'h00, 0, 8'hFF);
    step();
    check("wd granted", 576'(mem_req.mem_req_load), 576'(1));
    check("wd flag pre", 576'(bus_timeout), 576'(0));
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("wd hold%0d", i), 576'(mem_req.mem_req_load), 576'(1));
      check($sformatf("wd noready%0d", i), 576'(ic_resp.mem_ready), 576'(0));
    end
    step();
    check("wd dropped", 576'(mem_req.mem_req_load), 576'(0));
    check("wd ic_ready", 576'(ic_resp.mem_ready), 576'(1));
    check("wd ic_data", 576'(ic_resp.mem_data), 576'(0));
    check("wd flag", 576'(bus_timeout), 576'(1));
    check("wd dc_resp", 576'(dc_resp), 576'(0));
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00);
    step();
    step();
    check("wd idle", 576'(busy), 576'(0));
    check("wd sticky", 576'(bus_timeout), 576'(1));

    // Reset in the middle of a GRANT aborts silently.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rs flags cleared", 576'({bus_timeout, proto_err}), 576'(0));
    drive(1, 0, 8'h50, 0, 0, 8'h00, 0, 8'h00);
    step();
    check("rs granted a", 576'(mem_req.mem_req_load), 576'(1));
    check("rs granted b", 576'(mem_req_b.mem_req_load), 576'(1));
    step();
    rst = 1'b1;
    mem_resp.mem_ready = 1'b1;
    mem_resp.mem_data  = {64{8'h99}};
    step();
    check("rs mem_req a", 576'(mem_req), 576'(0));
    check("rs ic_resp a", 576'(ic_resp), 576'(0));
    check("rs dc_resp a", 576'(dc_resp), 576'(0));
    check("rs misc a", 576'({busy, bus_timeout, proto_err}), 576'(0));
    check("rs mem_req b", 576'(mem_req_b), 576'(0));
    check("rs ic_resp b", 576'(ic_resp_b), 576'(0));
    check("rs misc b", 576'({busy_b, bus_timeout_b, proto_err_b}), 576'(0));
    rst = 1'b0;
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00);
    step();
    check("rs no late ready", 576'(ic_resp.mem_ready), 576'(0));
    check("rs idle", 576'(busy), 576'(0));
    drive(1, 0, 8'h50, 1, 0, 8'h60, 0, 8'h00);
    step();
    check("rs ic_first addr", 576'(mem_req_b.mem_req_addr), 576'(8'h50));
    check("rs dc_first addr", 576'(mem_req.mem_req_addr), 576'(8'h60));
    mem_resp.mem_ready = 1'b1;
    step();
    check("rs ic_first ready", 576'({ic_resp_b.mem_ready, dc_resp_b.mem_ready}), 576'(2'b10));
    check("rs dc_first ready", 576'({ic_resp.mem_ready, dc_resp.mem_ready}), 576'(2'b01));
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00);
    step();
    step();
    check("rs both idle", 576'({busy, busy_b}), 576'(0));

    // Master holds its request after ready: stay in DROP, ignore spurious ready.
    drive(1, 0, 8'h44, 0, 0, 8'h00, 0, 8'h00);
    step();
    mem_resp.mem_ready = 1'b1;
    mem_resp.mem_data  = {64{8'h66}};
    step();
    check("dr ic_ready", 576'(ic_resp.mem_ready), 576'(1));
    check("dr ic_data", 576'(ic_resp.mem_data), 576'({64{8'h66}}));
    mem_resp.mem_ready = 1'b0;
    step();
    check("dr hold0 busy", 576'(busy), 576'(1));
    drive(1, 0, 8'h44, 1, 0, 8'h70, 1, 8'h88);
    for (int i = 1; i < 3; i++) begin
      step();
      check($sformatf("dr hold%0d busy", i), 576'(busy), 576'(1));
      check($sformatf("dr hold%0d req", i), 576'(mem_req), 576'(0));
      check($sformatf("dr hold%0d ready", i), 576'({ic_resp.mem_ready, dc_resp.mem_ready}), 576'(0));
    end
    drive(0, 0, 8'h00, 1, 0, 8'h70, 0, 8'h00);
    step();
    check("dr release idle", 576'(busy), 576'(0));
    check("dr release req", 576'(mem_req), 576'(0));
    step();
    check("dr dc grant", 576'(mem_req.mem_req_load), 576'(1));
    check("dr dc addr", 576'(mem_req.mem_req_addr), 576'(8'h70));
    mem_resp.mem_ready = 1'b1;
    mem_resp.mem_data  = {64{8'h12}};
    step();
    check("dr dc ready", 576'({ic_resp.mem_ready, dc_resp.mem_ready}), 576'(2'b01));
    check("dr dc data", 576'(dc_resp.mem_data), 576'({64{8'h12}}));
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00);
    step();
    step();
    check("dr final idle", 576'(busy), 576'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
